ln_group_dot: RTL and testbench



---
 rtl/ln_pkg.sv | 17 +
 rtl/ln_group_dot_if.sv | 45 ++++
 rtl/ln_mac.sv | 45 ++++
 rtl/ln_group_dot.sv | 144 ++++++++++++++
 tb/tb_ln_group_dot.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ln_pkg.sv
// Shared constants and sample/weight/result types for the layer-norm
// datapath and its consumers.
//
// The result width is exact for a full group: one full-width product
// (DW+WW bits) plus clog2(N) growth bits for the N-term sum.
package ln_pkg;

  localparam int LN_N  = 8;
  localparam int LN_DW = 8;
  localparam int LN_WW = 8;
  localparam int LN_RW = LN_DW + LN_WW + $clog2(LN_N);

  typedef logic signed [LN_DW-1:0] sample_t;
  typedef logic signed [LN_WW-1:0] weight_t;
  typedef logic signed [LN_RW-1:0] result_t;

endpackage

// File: rtl/ln_group_dot_if.sv
// Stream bundle for ln_group_dot.
//
// master : the producer/controller side. It drives clr, the weight stream
//          and the sample stream, and observes the results and err.
// slave  : the ln_group_dot side.
//
// Signals
//   clr       synchronous clear of the group index and running maximum
//   w_valid   weight tap valid
//   w_data    signed weight tap, tap 0 first
//   in_valid  sample valid
//   in_data   signed sample
//   out_valid one-cycle pulse per completed group
//   out_data  signed dot product of the group
//   out_grp   group index since the last clr/reset
//   out_max   qualifies out_valid: strictly greater than all earlier results
//   err       one-cycle pulse per cycle with a rejected beat
interface ln_group_dot_if #(
  parameter int DW = 8,
  parameter int WW = 8,
  parameter int RW = 19
) ();

  logic                 clr;
  logic                 w_valid;
  logic signed [WW-1:0] w_data;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic signed [RW-1:0] out_data;
  logic [7:0]           out_grp;
  logic                 out_max;
  logic                 err;

  modport master (
    output clr, w_valid, w_data, in_valid, in_data,
    input  out_valid, out_data, out_grp, out_max, err
  );

  modport slave (
    input  clr, w_valid, w_data, in_valid, in_data,
    output out_valid, out_data, out_grp, out_max, err
  );

endinterface

// File: rtl/ln_mac.sv
// Registered multiply-accumulate.
//
// Ports
//   clk, rst_n  clock, async active-low reset
//   en          update the accumulator this cycle
//   load        start a new sum (accumulator restarts from the product)
//   a, b        signed multiplicand / multiplier
//   acc_nxt     value the accumulator takes if en is high; exposed so the
//               caller can capture a finished sum without an extra cycle
module ln_mac #(
  parameter int DW = 8,
  parameter int WW = 8,
  parameter int RW = 19
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 load,
  input  logic signed [DW-1:0] a,
  input  logic signed [WW-1:0] b,
  output logic signed [RW-1:0] acc_nxt
);

  localparam int PW = DW + WW;

  logic signed [PW-1:0] prod;
  logic signed [RW-1:0] prod_ext;
  logic signed [RW-1:0] acc_q;
  logic signed [RW-1:0] acc_base;

  // Both operands are signed, so the multiply is a full signed product.
  assign prod     = a * b;
  assign prod_ext = {{(RW-PW){prod[PW-1]}}, prod};
  assign acc_base = load ? '0 : acc_q;
  assign acc_nxt  = acc_base + prod_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_nxt;
    end
  end

endmodule

// File: rtl/ln_group_dot.sv
// Grouped dot product behind the layer-norm stage.
//
// Samples arrive in groups of N. Each group is multiplied tap by tap with
// an N-entry weight vector that was loaded serially beforehand, and one
// result per group is emitted with a running group index and a flag that
// marks a new running maximum.
//
// Ports
//   clk    clock
//   rst_n  async active-low reset; clears weights, counters, outputs
//   bus    ln_group_dot_if.slave (see the interface for signal meanings)
//
// Beat acceptance
//   weight beat : only at a group boundary (sk==0) with no sample present
//   sample beat : only with a complete weight set (weights_ok) and no reload
//                 in progress (wk==0), and not alongside a weight beat
//   A weight beat and a sample beat in the same cycle are both dropped:
//   neither side is given priority. Any dropped beat raises err for one
//   cycle; several drops in one cycle give a single pulse.
module ln_group_dot
  import ln_pkg::*;
#(
  parameter int N  = LN_N,
  parameter int DW = LN_DW,
  parameter int WW = LN_WW,
  localparam int RW = DW + WW + $clog2(N),
  localparam int KW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  ln_group_dot_if.slave bus
);

  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  logic signed [WW-1:0] w_q [N];
  logic [KW-1:0]        wk;
  logic [KW-1:0]        sk;
  logic                 weights_ok;
  logic [7:0]           grp;
  logic signed [RW-1:0] best;
  logic                 best_valid;

  logic                 w_acc;
  logic                 s_acc;
  logic                 w_rej;
  logic                 s_rej;
  logic                 last;
  logic signed [RW-1:0] acc_nxt;
  logic                 is_max;
  logic [7:0]           grp_cur;

  assign w_acc = bus.w_valid && (sk == '0) && !bus.in_valid;
  assign s_acc = bus.in_valid && weights_ok && (wk == '0) && !bus.w_valid;
  assign w_rej = bus.w_valid && !w_acc;
  assign s_rej = bus.in_valid && !s_acc;
  assign last  = s_acc && (sk == K_LAST);

  // A clear coinciding with a completing group applies to that group: it
  // becomes group 0 and the first result of the new run.
  assign grp_cur = bus.clr ? 8'd0 : grp;
  assign is_max  = bus.clr || !best_valid || (acc_nxt > best);

  ln_mac #(
    .DW (DW),
    .WW (WW),
    .RW (RW)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (s_acc),
    .load    (sk == '0),
    .a       (bus.in_data),
    .b       (w_q[sk]),
    .acc_nxt (acc_nxt)
  );

  // Weight file and tap counter. A reload while weights_ok is set keeps
  // weights_ok high; samples are held off by wk!=0 until the last tap lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        w_q[i] <= '0;
      end
      wk         <= '0;
      weights_ok <= 1'b0;
    end else if (w_acc) begin
      w_q[wk] <= bus.w_data;
      if (wk == K_LAST) begin
        wk         <= '0;
        weights_ok <= 1'b1;
      end else begin
        wk <= wk + 1'b1;
      end
    end
  end

  // Sample position within the group; N is a power of two so it wraps
  // naturally. Gaps simply hold it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sk <= '0;
    end else if (s_acc) begin
      sk <= sk + 1'b1;
    end
  end

  // Result register, group counter and running-maximum tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_grp   <= '0;
      bus.out_max   <= 1'b0;
      grp           <= '0;
      best          <= '0;
      best_valid    <= 1'b0;
    end else begin
      bus.out_valid <= last;
      bus.out_max   <= last && is_max;
      if (last) begin
        bus.out_data <= acc_nxt;
        bus.out_grp  <= grp_cur;
        grp          <= grp_cur + 8'd1;
        if (is_max) begin
          best       <= acc_nxt;
          best_valid <= 1'b1;
        end
      end else if (bus.clr) begin
        grp        <= '0;
        best_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.err <= 1'b0;
    end else begin
      bus.err <= w_rej || s_rej;
    end
  end

endmodule

// File: tb/tb_ln_group_dot.sv
// Self-checking bench for ln_group_dot: directed cases from the test plan
// followed by a randomized stream, all compared against a group-level
// reference model (weights array + queue of the current group's samples).
module tb_ln_group_dot;
  import ln_pkg::*;

  logic clk;
  logic rst_n;

  ln_group_dot_if #(.DW(LN_DW), .WW(LN_WW), .RW(LN_RW)) bus ();

  ln_group_dot #(.N(LN_N), .DW(LN_DW), .WW(LN_WW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int     m_w [LN_N];
  int     m_wk;
  bit     m_ok;
  int     m_q [$];
  int     m_grp;
  longint m_best;
  bit     m_bv;

  bit     exp_valid, exp_err, exp_max;
  longint exp_data;
  int     exp_grp;

  task automatic model_reset();
    for (int i = 0; i < LN_N; i++) m_w[i] = 0;
    m_wk = 0; m_ok = 0; m_q.delete(); m_grp = 0; m_best = 0; m_bv = 0;
  endtask

  task automatic model_step(input bit c, input bit wv, input int wd,
                            input bit iv, input int id);
    bit wa, sa;
    longint dot;
    wa = wv && (m_q.size() == 0) && !iv;
    sa = iv && m_ok && (m_wk == 0) && !wv;
    exp_err   = (wv && !wa) || (iv && !sa);
    exp_valid = 0;
    if (wa) begin
      m_w[m_wk] = wd;
      m_wk++;
      if (m_wk == LN_N) begin m_wk = 0; m_ok = 1; end
    end
    if (sa) m_q.push_back(id);
    if (m_q.size() == LN_N) begin
      dot = 0;
      for (int i = 0; i < LN_N; i++) dot += longint'(m_w[i]) * longint'(m_q[i]);
      m_q.delete();
      if (c) begin m_grp = 0; m_bv = 0; end
      exp_valid = 1;
      exp_data  = dot;
      exp_grp   = m_grp;
      m_grp     = (m_grp + 1) % 256;
      exp_max   = !m_bv || (dot > m_best);
      if (exp_max) begin m_best = dot; m_bv = 1; end
    end else if (c) begin
      m_grp = 0; m_bv = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  longint last_data;
  int     last_grp;
  int     last_max;
  int     n_valid;
  int     n_err;

  task automatic step(input bit c, input bit wv, input int wd,
                      input bit iv, input int id);
    bus.clr      = c;
    bus.w_valid  = wv;
    bus.w_data   = weight_t'(wd);
    bus.in_valid = iv;
    bus.in_data  = sample_t'(id);
    model_step(c, wv, wd, iv, id);
    @(posedge clk);
    #1;
    chk("out_valid", longint'(bus.out_valid), longint'(exp_valid));
    chk("err", longint'(bus.err), longint'(exp_err));
    if (exp_valid) begin
      chk("out_data", longint'(bus.out_data), exp_data);
      chk("out_grp", longint'(bus.out_grp), longint'(exp_grp));
      chk("out_max", longint'(bus.out_max), longint'(exp_max));
    end
    if (bus.out_valid) begin
      last_data = longint'(bus.out_data);
      last_grp  = int'(bus.out_grp);
      last_max  = int'(bus.out_max);
      n_valid++;
    end
    if (bus.err) n_err++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  int pat [LN_N];

  task automatic load_pat();
    for (int i = 0; i < LN_N; i++) step(0, 1, pat[i], 0, 0);
  endtask

  task automatic send_pat(input int gap_after, input int gap_len);
    for (int i = 0; i < LN_N; i++) begin
      step(0, 0, 0, 1, pat[i]);
      if (i + 1 == gap_after)
        for (int g = 0; g < gap_len; g++) idle();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, longint'(bus.out_valid), 0);
    chk({tag, "_data"}, longint'(bus.out_data), 0);
    chk({tag, "_grp"}, longint'(bus.out_grp), 0);
    chk({tag, "_max"}, longint'(bus.out_max), 0);
    chk({tag, "_err"}, longint'(bus.err), 0);
  endtask

  task automatic apply_reset();
    bus.clr = 0; bus.w_valid = 0; bus.w_data = '0; bus.in_valid = 0; bus.in_data = '0;
    rst_n = 0;
    #1;
    check_zero_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
  endtask

  longint ref_gapless;

  initial begin
    rst_n = 0;
    n_valid = 0; n_err = 0;
    apply_reset();
    idle();

    // samples before any weight load: rejected, no result
    n_err = 0; n_valid = 0;
    step(0, 0, 0, 1, 5);
    step(0, 0, 0, 1, 6);
    idle();
    chk("noload_err", n_err, 2);
    chk("noload_valid", n_valid, 0);

    // weights all +1, samples 1..8
    for (int i = 0; i < LN_N; i++) pat[i] = 1;
    load_pat();
    for (int i = 0; i < LN_N; i++) pat[i] = i + 1;
    n_valid = 0;
    send_pat(0, 0);
    chk("tp1_data", last_data, 36);
    chk("tp1_grp", last_grp, 0);
    chk("tp1_max", last_max, 1);
    chk("tp1_count", n_valid, 1);

    // same group with a 5-cycle gap after sample 3
    ref_gapless = last_data;
    send_pat(3, 5);
    chk("gap_data", last_data, ref_gapless);
    idle();

    // alternating weights; clear first so the first result is group 0
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < LN_N; i++) pat[i] = (i % 2 == 0) ? 1 : -1;
    load_pat();
    for (int i = 0; i < LN_N; i++) pat[i] = 4;
    send_pat(0, 0);
    chk("alt0_data", last_data, 0);
    chk("alt0_max", last_max, 1);
    for (int i = 0; i < LN_N; i++) pat[i] = (i % 2 == 0) ? 4 : -4;
    send_pat(0, 0);
    chk("alt1_data", last_data, 32);
    chk("alt1_grp", last_grp, 1);
    chk("alt1_max", last_max, 1);

    // w_valid at sk=3 is dropped; weights stay alternating
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, pat[i]);
    n_err = 0;
    step(0, 1, 100, 0, 0);
    chk("wmid_err", n_err, 1);
    for (int i = 3; i < LN_N; i++) step(0, 0, 0, 1, pat[i]);
    chk("wmid_data", last_data, 32);

    // simultaneous w_valid and in_valid at sk=0: both dropped, one pulse
    n_err = 0;
    step(0, 1, 50, 1, 7);
    idle();
    chk("coll_err", n_err, 1);
    send_pat(0, 0);
    chk("coll_data", last_data, 32);

    // extremes
    for (int i = 0; i < LN_N; i++) pat[i] = -128;
    load_pat();
    send_pat(0, 0);
    chk("ext_pos", last_data, 131072);
    for (int i = 0; i < LN_N; i++) pat[i] = 127;
    load_pat();
    for (int i = 0; i < LN_N; i++) pat[i] = -128;
    send_pat(0, 0);
    chk("ext_neg", last_data, -130048);
    chk("ext_neg_max", last_max, 0);

    // clr with equal repeated results
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < LN_N; i++) pat[i] = i - 3;
    send_pat(0, 0);
    chk("clr0_grp", last_grp, 0);
    chk("clr0_max", last_max, 1);
    send_pat(0, 0);
    chk("clr1_grp", last_grp, 1);
    chk("clr1_max", last_max, 0);

    // clr coincident with a completing sample
    for (int i = 0; i < LN_N - 1; i++) step(0, 0, 0, 1, pat[i]);
    step(1, 0, 0, 1, pat[LN_N-1]);
    chk("clrhit_grp", last_grp, 0);
    chk("clrhit_max", last_max, 1);
    send_pat(0, 0);
    chk("clrhit_next", last_grp, 1);

    // reset mid-group clears weights and outputs
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, pat[i]);
    apply_reset();
    n_err = 0;
    step(0, 0, 0, 1, 3);
    chk("postrst_err", n_err, 1);

    // randomized stream
    for (int i = 0; i < LN_N; i++) pat[i] = int'($urandom_range(0, 255)) - 128;
    load_pat();
    for (int n = 0; n < 3000; n++) begin
      bit c, wv, iv;
      int wd, id;
      c  = ($urandom_range(0, 99) < 2);
      wv = ($urandom_range(0, 99) < 5);
      iv = ($urandom_range(0, 99) < 70);
      wd = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 1) == 1) id = int'($urandom_range(0, 6)) - 3;
      else id = int'($urandom_range(0, 255)) - 128;
      step(c, wv, wd, iv, id);
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
